// File: rtl/flag_stack_reg.sv
// rtl/flag_stack_reg.sv - condition-flag register with masked/sticky update and shadow stack
//
// Purpose: holds WIDTH condition flags (default {N, V, Z}) between the ALU and
// the branch logic. It supports per-flag update masks, sticky bits and
// explicit clears. A DEPTH-entry LIFO shadow stack saves and restores the
// flags across interrupt or call entry and exit.
//
// Ports:
//   i_clk       clock, all state changes on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_flag_en   current instruction may update flags (gates i_write only)
//   i_write     per-flag update mask
//   i_in        new flag values from the ALU
//   i_clr       per-flag explicit clear (honoured regardless of i_flag_en)
//   i_push      save current flags onto the shadow stack
//   i_pop       restore flags from the top of the shadow stack
//   o_flag_out  committed flags
//   o_count     occupied stack entries
//   o_empty     o_count == 0
//   o_full      o_count == DEPTH
//   o_err       one-cycle pulse after a push when full or a pop when empty
module flag_stack_reg #(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] STICKY_MASK = '0,
  localparam int              CW          = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flag_en,
  input  logic [WIDTH-1:0] i_write,
  input  logic [WIDTH-1:0] i_in,
  input  logic [WIDTH-1:0] i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_flag_out,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic             w_empty;
  logic             w_full;
  logic [WIDTH-1:0] w_upd;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_swap;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;
  logic             w_err_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Normal per-bit update: clear beats write, sticky bits only OR in ones.
  always_comb begin
    w_upd = r_flags;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_clr[i]) begin
        w_upd[i] = 1'b0;
      end else if (i_flag_en && i_write[i]) begin
        w_upd[i] = STICKY_MASK[i] ? (r_flags[i] | i_in[i]) : i_in[i];
      end
    end
  end

  // push+pop on an empty stack degenerates to a plain push, so it is folded
  // into w_push_only; DEPTH >= 1 guarantees an empty stack is never full.
  assign w_push_only = i_push && !w_full && (!i_pop || w_empty);
  assign w_pop_only  = i_pop && !i_push && !w_empty;
  assign w_swap      = i_push && i_pop && !w_empty;
  assign w_err_nxt   = (i_push && !i_pop && w_full) || (i_pop && !i_push && w_empty);

  // Indices are only used when in range (not full for write, not empty for top),
  // so the truncation to AW bits is safe.
  assign w_wr_idx  = AW'(r_count);
  assign w_top_idx = AW'(r_count - CW'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flags <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_err <= w_err_nxt;

      if (w_push_only) begin
        r_stack[w_wr_idx] <= r_flags;
      end else if (w_swap) begin
        r_stack[w_top_idx] <= r_flags;
      end

      // A restore (pop or swap) overrides any write/clear in the same cycle.
      if (w_pop_only || w_swap) begin
        r_flags <= r_stack[w_top_idx];
      end else begin
        r_flags <= w_upd;
      end

      if (w_push_only) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_only) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_flag_out = r_flags;
  assign o_count    = r_count;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_err      = r_err;

endmodule

// File: doc/flag_stack_reg.md
# flag_stack_reg

Parametrised condition-flag register for the CPU datapath: holds WIDTH flags (N/V/Z by default) with per-flag update masks, sticky bits and explicit clears, plus a DEPTH-entry hardware shadow stack for saving and restoring flags across interrupt or call entry and exit. It sits between the ALU flag outputs and the branch-condition logic. It generalises the three-bit N/V/Z flag register to arbitrary width and adds context save and restore.

## Interface
- WIDTH, 3, number of flags; bit order for default is {N, V, Z}
- DEPTH, 4, shadow stack entries (≥1)
- STICKY_MASK, {WIDTH{1'b0}}, per-bit: 1 = sticky (update only ORs in ones)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flag_en  in  1  current instruction is allowed to update flags
- write  in  WIDTH  per-flag update mask
- in  in  WIDTH  new flag values from ALU
- clr  in  WIDTH  per-flag explicit clear
- push  in  1  save current flags to shadow stack
- pop  in  1  restore flags from top of shadow stack
- flag_out  out  WIDTH  committed flags
- count  out  $clog2(DEPTH+1)  occupied stack entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- err  out  1  one-cycle pulse: push when full or pop when empty

## Operation
- Reset (rst low, asynchronous): flag_out=0, count=0, empty=1, full=0, err=0, all stack entries=0.
- Per-bit next value (no valid pop), priority high→low:
  - clr[i]=1 → 0
  - flag_en & write[i]:
    - non-sticky: in[i]
    - sticky: flag_out[i] | in[i]
  - else hold
- write is ignored when flag_en=0; clr is honoured regardless of flag_en.
- Push (push=1, pop=0, !full):
  - stack[count] ← current flag_out (pre-update value)
  - count+1
  - flag update/clear still applies to flag_out the same cycle.
- Pop (pop=1, push=0, !empty):
  - flag_out ← stack[count-1]; count-1
  - write/clr are ignored that cycle (restore wins).
- Push when full: stack unchanged, err=1 next cycle; flag update still applies.
- Pop when empty: flags follow normal update/clear rules, err=1 next cycle.
- Push and pop in the same cycle:
  - if !empty, swap: stack[count-1] ← current flag_out, flag_out ← old stack[count-1], count unchanged, write/clr ignored.
  - if empty: treated as push only (no err).
- Stack is LIFO, indexed by count; no wrap-around, and overflow never overwrites entries.
- Entries above count are don't-care; they need not be cleared on pop.

## Timing
- All outputs are registered; flag_out, count, empty and full reflect an operation on the edge after it is presented.
- Latency:
  - update → flag_out: 1 cycle.
  - pop → restored flag_out: 1 cycle.
  - A value pushed at edge k is poppable at edge k+1.
- err is high for exactly one cycle per offending request. Back-to-back bad requests give a continuous high err.
- Reset assertion mid-operation clears everything immediately, independent of clk. Deassertion is expected synchronous to clk; the first operation is accepted on the first rising edge with rst high.
- No combinational path from inputs to outputs.

## Test plan
- Update mask:
  - Reset, then flag_en=1, write=3'b101, in=3'b111 → flag_out=3'b101.
  - Next cycle flag_en=0, write=3'b111, in=3'b000 → flag_out stays 3'b101.
- Sticky and clear: STICKY_MASK=3'b010.
  - flag_en=1, write=3'b010, in=3'b010 → V=1.
  - Then in=3'b000 same mask → V stays 1.
  - clr=3'b010 with same update → V=0.
- Push/pop round trip:
  - flags=3'b110, push → count=1.
  - Update to 3'b001, then pop → flag_out=3'b110, count=0, empty=1.
- Overflow/underflow (DEPTH=4):
  - Five consecutive pushes → count=4, full=1, err high only in the cycle after the fifth.
  - Five pops → count=0, err high only after the fifth, flags equal the first-pushed value.
- Simultaneous push+pop:
  - Stack top=3'b011, flags=3'b100, push=pop=1 → flag_out=3'b011, top=3'b100, count unchanged.
  - With empty stack → count=1, err=0.
- Asynchronous reset:
  - Assert rst low between edges with count=3, flags=3'b111 → outputs 0 / empty=1 immediately, without a clock edge.
